// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, nop encoding, primary opcodes.
// No logic; pure typedefs, constants and a word-alignment helper.
// Imported by the fetch stage and the control unit.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        BUFFERED = 2'd2,
        DRAIN    = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction word that arrives while decode is stalled.
// Latency: data_o/valid_o update one cycle after load_i.
// Backpressure: none; the owner only loads when the entry is free, clear wins over load.
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] data_i,
    output logic        valid_o,
    output logic [31:0] data_o
);

    logic        valid_q;
    logic [31:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= 32'h0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            data_q  <= 32'h0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch FSM plus IF/ID register: req/ack to imem, skid on stall, redirect with squash.
// Latency: ack in cycle N appears in IF/ID at N+1; one instr/cycle with zero-wait memory.
// Backpressure: stall holds IF/ID and PC; a stalled response parks in the skid buffer.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic [5:0]  ifid_opcode
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic         ifid_vld_q, ifid_vld_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc4_q, ifid_pc4_d;
    logic         skid_load, skid_clear, skid_vld;
    logic [31:0]  skid_dat;
    logic         bubble;
    logic [31:0]  pc_plus4;
    logic [31:0]  target;

    assign pc_plus4 = pc_q + 32'd4;
    assign target   = align_word(branch_target);

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (imem_rdata),
        .valid_o (skid_vld),
        .data_o  (skid_dat)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        ifid_vld_d   = ifid_vld_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        bubble       = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (branch_taken) begin
                    pc_d   = target;
                    bubble = 1'b1;
                    // An unacked request must still be completed before the new address goes out.
                    if (!imem_ack) begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end else if (imem_ack && !stall) begin
                    ifid_vld_d   = 1'b1;
                    ifid_instr_d = imem_rdata;
                    ifid_pc4_d   = pc_plus4;
                    pc_d         = pc_plus4;
                end else if (imem_ack) begin
                    skid_load = 1'b1;
                    state_d   = BUFFERED;
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end
            BUFFERED: begin
                if (branch_taken) begin
                    skid_clear = 1'b1;
                    pc_d       = target;
                    bubble     = 1'b1;
                    state_d    = FETCH;
                end else if (!stall) begin
                    ifid_vld_d   = skid_vld;
                    ifid_instr_d = skid_vld ? skid_dat : NOP_INSTR;
                    ifid_pc4_d   = pc_plus4;
                    pc_d         = pc_plus4;
                    skid_clear   = 1'b1;
                    state_d      = FETCH;
                end
            end
            DRAIN: begin
                bubble = 1'b1;
                if (branch_taken) begin
                    pc_d = target;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bubble) begin
            ifid_vld_d   = 1'b0;
            ifid_instr_d = NOP_INSTR;
            ifid_pc4_d   = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0;
            ifid_vld_q   <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            ifid_vld_q   <= ifid_vld_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    // Request side depends on registered state only, never on imem_ack.
    assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign ifid_valid  = ifid_vld_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_pc4    = ifid_pc4_q;
    assign ifid_opcode = ifid_instr_q[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus hand-written DRAIN/reset sequences.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic [5:0]  ifid_opcode;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_opcode   (ifid_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stl;
        logic        br;
        logic [31:0] tgt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_vld;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic stl,
                                input logic br, input logic [31:0] tgt, input logic exp_req,
                                input logic [31:0] exp_addr, input logic exp_vld,
                                input logic [31:0] exp_instr, input logic [31:0] exp_pc4);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.stl = stl; v.br = br; v.tgt = tgt;
        v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_vld = exp_vld;
        v.exp_instr = exp_instr; v.exp_pc4 = exp_pc4;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e_instr;
        //                ack rdata         stl br tgt           req addr          vld instr         pc4
        vecs[0]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0,         32'h0);
        vecs[1]  = mk(1, 32'h2008_0005, 0, 0, 32'h0,         1, 32'h0000_0000, 1, 32'h2008_0005, 32'h4);
        vecs[2]  = mk(1, 32'h8C09_0004, 0, 0, 32'h0,         1, 32'h0000_0004, 1, 32'h8C09_0004, 32'h8);
        vecs[3]  = mk(1, 32'hAD09_0000, 1, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h8C09_0004, 32'h8);
        vecs[4]  = mk(0, 32'h0,         1, 0, 32'h0,         0, 32'h0000_0008, 1, 32'h8C09_0004, 32'h8);
        vecs[5]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 32'h0000_0008, 1, 32'hAD09_0000, 32'hC);
        vecs[6]  = mk(1, 32'h0000_0020, 0, 1, 32'h40,        1, 32'h0000_000C, 0, 32'h0,         32'h0);
        vecs[7]  = mk(1, 32'h1000_0003, 0, 0, 32'h0,         1, 32'h0000_0040, 1, 32'h1000_0003, 32'h44);
        vecs[8]  = mk(1, 32'hDEAD_BEEF, 0, 1, 32'h13,        1, 32'h0000_0044, 0, 32'h0,         32'h0);
        vecs[9]  = mk(0, 32'h0,         0, 1, 32'h80,        1, 32'h0000_0010, 0, 32'h0,         32'h0);
        vecs[10] = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0010, 0, 32'h0,         32'h0);
        vecs[11] = mk(1, 32'h1234_5678, 0, 0, 32'h0,         1, 32'h0000_0010, 0, 32'h0,         32'h0);
        vecs[12] = mk(1, 32'h0109_5020, 0, 0, 32'h0,         1, 32'h0000_0080, 1, 32'h0109_5020, 32'h84);
        vecs[13] = mk(1, 32'hAC0A_0008, 1, 0, 32'h0,         1, 32'h0000_0084, 1, 32'h0109_5020, 32'h84);
        vecs[14] = mk(0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0000_0084, 0, 32'h0,         32'h0);
        vecs[15] = mk(0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0);
        vecs[16] = mk(1, 32'h2108_FFFF, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'h2108_FFFF, 32'h0);
        vecs[17] = mk(0, 32'h0,         1, 0, 32'h0,         1, 32'h0000_0000, 1, 32'h2108_FFFF, 32'h0);
        vecs[18] = mk(0, 32'h0,         0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0,         32'h0);

        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        #12;
        check("rst_req",    32'(imem_req),    32'h0);
        check("rst_addr",   imem_addr,        32'h0);
        check("rst_vld",    32'(ifid_valid),  32'h0);
        check("rst_instr",  ifid_instr,       32'h0);
        check("rst_pc4",    ifid_pc4,         32'h0);
        check("rst_opcode", 32'(ifid_opcode), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            imem_ack      = vecs[i].ack;
            imem_rdata    = vecs[i].rdata;
            stall         = vecs[i].stl;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            #1;
            check($sformatf("v%0d_req", i),  32'(imem_req), 32'(vecs[i].exp_req));
            check($sformatf("v%0d_addr", i), imem_addr,     vecs[i].exp_addr);
            @(posedge clk);
            #1;
            e_instr = vecs[i].exp_instr;
            check($sformatf("v%0d_vld", i),    32'(ifid_valid),  32'(vecs[i].exp_vld));
            check($sformatf("v%0d_instr", i),  ifid_instr,       e_instr);
            check($sformatf("v%0d_pc4", i),    ifid_pc4,         vecs[i].exp_pc4);
            check($sformatf("v%0d_opcode", i), 32'(ifid_opcode), 32'(e_instr[31:26]));
            @(negedge clk);
        end

        // FETCH at pc 0 with no ack: redirect to 0x200 enters DRAIN holding address 0.
        imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
        #1;
        check("dr0_addr", imem_addr, 32'h0);
        @(negedge clk);
        branch_target = 32'h300;
        #1;
        check("dr1_req",  32'(imem_req), 32'h1);
        check("dr1_addr", imem_addr,     32'h0);
        @(negedge clk);
        branch_taken = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #1;
        check("dr2_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        check("dr2_vld", 32'(ifid_valid), 32'h0);
        @(negedge clk);
        imem_rdata = 32'hAC0A_0008;
        #1;
        check("dr3_addr", imem_addr, 32'h300);
        @(posedge clk);
        #1;
        check("dr3_vld",   32'(ifid_valid), 32'h1);
        check("dr3_instr", ifid_instr,      32'hAC0A_0008);
        check("dr3_pc4",   ifid_pc4,        32'h304);

        // Mid-request reset must drop req and clear IF/ID without a clock edge.
        imem_ack = 1'b0;
        #1;
        check("ar_pre_req", 32'(imem_req), 32'h1);
        rst_n = 1'b0;
        #1;
        check("ar_req",   32'(imem_req),   32'h0);
        check("ar_addr",  imem_addr,       32'h0);
        check("ar_vld",   32'(ifid_valid), 32'h0);
        check("ar_instr", ifid_instr,      32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_idle_req", 32'(imem_req), 32'h0);
        @(posedge clk);
        #1;
        check("ar_first_req", 32'(imem_req), 32'h1);
        check("ar_first_addr", imem_addr,    32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the MIPS core. Holds the PC and issues word fetches to instruction memory over a req/ack handshake. Presents the fetched instruction, its PC+4 and a valid bit to decode; `ifid_opcode` drives the control unit's 6-bit opcode input directly. Supports decode-side stall, a one-entry skid buffer for responses that arrive during a stall, and branch redirect with squash of in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request. Held until `imem_ack`.
- `imem_addr` out 32: fetch address. Equals `pc` and is stable while `imem_req`=1.
- `imem_ack` in 1: response valid. Valid only while `imem_req`=1; may arrive in the same cycle as req.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `stall` in 1: decode cannot accept. IF/ID holds and PC does not advance.
- `branch_taken` in 1: redirect request from execute.
- `branch_target` in 32: redirect address. Bits [1:0] are ignored and forced to 0.
- `ifid_valid` out 1: IF/ID holds a real instruction.
- `ifid_instr` out 32: instruction word. 32'h0 (nop) whenever `ifid_valid`=0.
- `ifid_pc4` out 32: PC of the instruction + 4.
- `ifid_opcode` out 6: `ifid_instr[31:26]`, routed to the control unit.

## Operation
- **IDLE:** reset state.
  - `imem_req`=0.
  - Goes to FETCH on the next edge.
- **FETCH:** `imem_req`=1, `imem_addr`=`pc`. Per cycle, in priority order:
  - `branch_taken`: `pc`←target; IF/ID←bubble.
    - With `imem_ack`: the response is discarded; stay in FETCH.
    - Without `imem_ack`: go to DRAIN.
  - `imem_ack`, no stall: IF/ID←{1, `imem_rdata`, `pc`+4}; `pc`←`pc`+4.
  - `imem_ack` with stall: skid buffer←`imem_rdata`; go to BUFFERED. IF/ID holds.
  - No ack: IF/ID holds if stalled; otherwise IF/ID←bubble.
- **BUFFERED:** `imem_req`=0.
  - `branch_taken`: discard the buffer; `pc`←target; IF/ID←bubble; go to FETCH.
  - Else `!stall`: IF/ID←{1, buffer, `pc`+4}; `pc`←`pc`+4; go to FETCH.
  - Else: hold.
- **DRAIN:** `imem_req`=1 at the old address, which is held in a separate `drain_addr` register.
  - `imem_ack` completes the old request; its data is discarded; go to FETCH.
  - A further `branch_taken` in DRAIN updates `pc` only.
  - IF/ID stays bubble.
- Precedence: `branch_taken` overrides `stall` in every state. A redirect always squashes IF/ID, even when stalled.
- PC arithmetic is modulo 2^32; wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset values:
  - state=IDLE, `pc`=`RESET_PC`.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `ifid_valid`=0, `ifid_instr`=0, `ifid_pc4`=0, `ifid_opcode`=0.
- First `imem_req`=1 is in the cycle after `rst_n` deasserts.
- Latency: an ack in cycle N (unstalled) gives `ifid_valid`=1 with that word in N+1.
  - With a zero-wait memory, throughput is one instruction per cycle.
- Stall released in cycle N while BUFFERED:
  - Buffered word appears in IF/ID at N+1.
  - The next fetch is issued in N+1.
- Redirect in cycle N: `imem_addr`=target from N+1, unless an unacked request forces DRAIN first.
- `rst_n` assertion mid-request drops `imem_req` immediately (asynchronously). The memory must tolerate an abandoned request.
- `imem_req`/`imem_addr` are decoded from registered state and `pc`/`drain_addr` only, with no combinational path from `imem_ack`.

## Structure
- `mips_pkg` holds:
  - the fetch state enum {IDLE, FETCH, BUFFERED, DRAIN};
  - `NOP_INSTR`=32'h0;
  - opcode constants (R-type 6'b000000, addi 6'b001000, lw 6'b100011, sw 6'b101011, beq 6'b000100), shared with the control unit.
- One sub-module, `fetch_skid_buffer`: a one-entry data register with load/clear/valid. All other logic stays in `fetch_stage`.

## Test plan
- **Reset and linear fetch:** release reset; memory acks same cycle with words 32'h2008_0005, 32'h8C09_0004.
  - Expect `imem_addr` 0x0 then 0x4.
  - Expect `ifid_pc4` 0x4 then 0x8; `ifid_opcode` 6'b001000 then 6'b100011.
- **Stall with ack:** assert `stall` while ack at 0x8 carries 32'hAD09_0000.
  - Expect state BUFFERED and `imem_req`=0.
  - Release stall: IF/ID=32'hAD09_0000 and `ifid_pc4`=0xC one cycle later; next req at 0xC.
- **Redirect with same-cycle ack:** `branch_taken`=1, target 0x40, together with an ack.
  - Expect the data discarded, `ifid_valid`=0 next cycle, next `imem_addr`=0x40.
- **Redirect during wait state:** memory delays the ack 3 cycles at 0x10; `branch_taken` to 0x80 in the first wait cycle.
  - Expect `imem_addr` held at 0x10 until ack, no valid output, then a req at 0x80.
- **Redirect while BUFFERED and stalled:**
  - Expect the buffer dropped, `ifid_valid`=0, a fetch from the target, and stall ignored for the squash.
- **PC wrap and target alignment:** run from 0xFFFF_FFFC → next `imem_addr`=0x0. Give `branch_target`=0x0000_0013 → fetch at 0x10.
